// File: rtl/washer_pkg.sv
// Shared encodings for the washer actuator stage: FSM state codes, drum speed codes
// and state classification helpers.
package washer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_OPTIONS   = 4'd1,
    ST_CONFIG    = 4'd2,
    ST_READY     = 4'd3,
    ST_WASH      = 4'd4,
    ST_RINSE     = 4'd5,
    ST_DRAIN     = 4'd6,
    ST_DRY       = 4'd7,
    ST_COMPLETE  = 4'd8,
    ST_FILL      = 4'd9,
    ST_CHECK_ERR = 4'd15
  } wm_state_t;

  typedef enum logic [1:0] {
    SPD_OFF  = 2'd0,
    SPD_LOW  = 2'd1,
    SPD_MED  = 2'd2,
    SPD_HIGH = 2'd3
  } speed_t;

  // Codes the FSM never produces (10..14) are folded onto Idle.
  function automatic wm_state_t decode_state(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15:
        decode_state = wm_state_t'(code);
      default:
        decode_state = ST_IDLE;
    endcase
  endfunction

  function automatic logic is_locking_state(input wm_state_t cs);
    is_locking_state = (cs == ST_FILL) || (cs == ST_WASH) || (cs == ST_RINSE) ||
                       (cs == ST_DRAIN) || (cs == ST_DRY);
  endfunction

endpackage

// File: rtl/washer_tumble_gen.sv
// Drum tumble pattern generator: forward, pause, reverse, pause, repeating.
// Outputs describe the cycle being registered downstream, so a restart takes effect at once.
module washer_tumble_gen #(
  parameter int unsigned TUMBLE_ON    = 8,
  parameter int unsigned TUMBLE_PAUSE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic active,
  output logic dir
);

  localparam int unsigned MAX_LEN = (TUMBLE_ON > TUMBLE_PAUSE) ? TUMBLE_ON : TUMBLE_PAUSE;
  localparam int unsigned CW      = $clog2(MAX_LEN) + 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(TUMBLE_ON - 1);
  localparam logic [CW-1:0] PAUSE_LAST = CW'(TUMBLE_PAUSE - 1);

  typedef enum logic [1:0] {PH_FWD, PH_PAUSE_F, PH_REV, PH_PAUSE_R} phase_t;

  phase_t          phase_q, phase_cur, phase_nx;
  logic [CW-1:0]   cnt_q, cnt_cur, cnt_nx;
  logic [CW-1:0]   last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_FWD;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    phase_cur = start ? PH_FWD : phase_q;
    cnt_cur   = start ? '0 : cnt_q;
    phase_nx  = phase_cur;
    cnt_nx    = cnt_cur;
    last      = ((phase_cur == PH_FWD) || (phase_cur == PH_REV)) ? ON_LAST : PAUSE_LAST;
    active    = run && ((phase_cur == PH_FWD) || (phase_cur == PH_REV));
    dir       = (phase_cur == PH_REV);
    if (run) begin
      if (cnt_cur >= last) begin
        cnt_nx = '0;
        case (phase_cur)
          PH_FWD:     phase_nx = PH_PAUSE_F;
          PH_PAUSE_F: phase_nx = PH_REV;
          PH_REV:     phase_nx = PH_PAUSE_R;
          default:    phase_nx = PH_FWD;
        endcase
      end else begin
        cnt_nx = cnt_cur + 1'b1;
      end
    end
  end

endmodule

// File: rtl/washer_actuator_ctrl.sv
// Actuator stage of the washer: decodes the FSM state into registered actuator drives
// and enforces door/fill safety interlocks with a sticky fault.
module washer_actuator_ctrl #(
  parameter int unsigned TUMBLE_ON    = 8,
  parameter int unsigned TUMBLE_PAUSE = 4,
  parameter int unsigned RAMP_LEN     = 6,
  parameter int unsigned UNLOCK_DELAY = 10,
  parameter int unsigned FILL_TIMEOUT = 50,
  parameter int unsigned BUZZ_LEN     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cs,
  input  logic       door_closed,
  input  logic       level_full,
  input  logic       level_empty,
  output logic       door_lock,
  output logic       inlet_valve,
  output logic       drain_pump,
  output logic       motor_en,
  output logic       motor_dir,
  output logic [1:0] motor_speed,
  output logic       buzzer,
  output logic       fault
);

  import washer_pkg::*;

  localparam int unsigned M1   = (TUMBLE_ON > TUMBLE_PAUSE) ? TUMBLE_ON : TUMBLE_PAUSE;
  localparam int unsigned M2   = (RAMP_LEN > UNLOCK_DELAY) ? RAMP_LEN : UNLOCK_DELAY;
  localparam int unsigned M3   = (FILL_TIMEOUT > BUZZ_LEN) ? FILL_TIMEOUT : BUZZ_LEN;
  localparam int unsigned M12  = (M1 > M2) ? M1 : M2;
  localparam int unsigned MAXP = (M12 > M3) ? M12 : M3;
  localparam int unsigned CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] UNLOCK_LIM = CW'(UNLOCK_DELAY);
  localparam logic [CW-1:0] FILL_LIM   = CW'(FILL_TIMEOUT);
  localparam logic [CW-1:0] RAMP_LIM   = CW'(RAMP_LEN);
  localparam logic [CW-1:0] BUZZ_LIM   = CW'(BUZZ_LEN);

  wm_state_t     st, prev_st;
  logic          entry, locking, lock_next;
  logic [CW-1:0] unlock_cnt, fill_cnt, fill_cnt_eff, ramp_cnt, buzz_cnt;
  logic          fill_to, valve_req, dry_run, tumble_run, motor_req, pump_req;
  logic          interlock, fault_next, enable, valve_next, motor_next, dir_next;
  logic          comp_entry, buzz_next;
  speed_t        speed_next;
  logic          t_start, t_active, t_dir;

  assign st         = decode_state(cs);
  assign entry      = (st != prev_st);
  assign tumble_run = (st == ST_WASH) || (st == ST_RINSE);
  assign t_start    = tumble_run && entry;

  washer_tumble_gen #(
    .TUMBLE_ON   (TUMBLE_ON),
    .TUMBLE_PAUSE(TUMBLE_PAUSE)
  ) u_tumble (
    .clk   (clk),
    .rst_n (rst_n),
    .start (t_start),
    .run   (tumble_run),
    .active(t_active),
    .dir   (t_dir)
  );

  always_comb begin
    locking      = is_locking_state(st);
    lock_next    = locking || (unlock_cnt != '0);
    fill_cnt_eff = ((st == ST_FILL) && entry) ? '0 : fill_cnt;
    fill_to      = (st == ST_FILL) && (fill_cnt_eff >= FILL_LIM);
    valve_req    = (st == ST_FILL) && !level_full && !fill_to;
    dry_run      = (st == ST_DRY) && level_empty;
    motor_req    = (tumble_run && t_active) || dry_run;
    pump_req     = (st == ST_DRAIN) || (st == ST_DRY);
    // Interlock looks at requested activity, so a door opened mid-run trips it
    // even though the enable gate below already forces valve and motor off.
    interlock    = !door_closed && lock_next && (valve_req || motor_req || pump_req);
    fault_next   = (st == ST_IDLE) ? 1'b0 : (fault || interlock || fill_to);
    enable       = door_closed && lock_next && !fault_next;
    valve_next   = valve_req && enable;
    motor_next   = motor_req && enable;
    speed_next   = SPD_OFF;
    dir_next     = motor_dir;
    if (motor_next) begin
      if (dry_run) begin
        speed_next = (ramp_cnt < RAMP_LIM) ? SPD_MED : SPD_HIGH;
        dir_next   = 1'b0;
      end else begin
        speed_next = (st == ST_RINSE) ? SPD_MED : SPD_LOW;
        dir_next   = t_dir;
      end
    end
    comp_entry = (st == ST_COMPLETE) && entry;
    buzz_next  = comp_entry || (buzz_cnt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_st     <= ST_IDLE;
      door_lock   <= 1'b0;
      inlet_valve <= 1'b0;
      drain_pump  <= 1'b0;
      motor_en    <= 1'b0;
      motor_dir   <= 1'b0;
      motor_speed <= '0;
      buzzer      <= 1'b0;
      fault       <= 1'b0;
      unlock_cnt  <= '0;
      fill_cnt    <= '0;
      ramp_cnt    <= '0;
      buzz_cnt    <= '0;
    end else begin
      prev_st     <= st;
      door_lock   <= lock_next;
      inlet_valve <= valve_next;
      drain_pump  <= pump_req;
      motor_en    <= motor_next;
      motor_dir   <= dir_next;
      motor_speed <= speed_next;
      buzzer      <= buzz_next;
      fault       <= fault_next;

      if (locking)                unlock_cnt <= UNLOCK_LIM;
      else if (unlock_cnt != '0)  unlock_cnt <= unlock_cnt - 1'b1;

      if (st == ST_FILL)          fill_cnt <= valve_next ? fill_cnt_eff + 1'b1 : fill_cnt_eff;

      if (!dry_run)               ramp_cnt <= '0;
      else if (ramp_cnt < RAMP_LIM) ramp_cnt <= ramp_cnt + 1'b1;

      if (comp_entry)             buzz_cnt <= BUZZ_LIM - 1'b1;
      else if (buzz_cnt != '0)    buzz_cnt <= buzz_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_washer_actuator_ctrl.sv
// Directed plus randomized bench for washer_actuator_ctrl against a cycle-level
// behavioural model built from the actuator rules.
module tb_washer_actuator_ctrl;

  localparam int ON = 8, PAUSE = 4, RAMP = 6, UNLOCK = 10, FILL_TO = 50, BUZZ = 5;
  localparam int PERIOD = 2 * (ON + PAUSE);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cs = 4'd0;
  logic       door_closed = 1'b1;
  logic       level_full = 1'b0;
  logic       level_empty = 1'b0;
  logic       door_lock, inlet_valve, drain_pump, motor_en, motor_dir, buzzer, fault;
  logic [1:0] motor_speed;

  int n_tests = 0;
  int n_fail  = 0;

  int m_prev, m_unlock, m_fill, m_tpos, m_ramp, m_buzz;
  bit m_fault, m_dir;
  logic [8:0] exp_v, got_v;

  washer_actuator_ctrl #(
    .TUMBLE_ON   (ON),
    .TUMBLE_PAUSE(PAUSE),
    .RAMP_LEN    (RAMP),
    .UNLOCK_DELAY(UNLOCK),
    .FILL_TIMEOUT(FILL_TO),
    .BUZZ_LEN    (BUZZ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .door_closed(door_closed),
    .level_full (level_full),
    .level_empty(level_empty),
    .door_lock  (door_lock),
    .inlet_valve(inlet_valve),
    .drain_pump (drain_pump),
    .motor_en   (motor_en),
    .motor_dir  (motor_dir),
    .motor_speed(motor_speed),
    .buzzer     (buzzer),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  function automatic bit is_lock(input int s);
    return (s == 9) || (s >= 4 && s <= 7);
  endfunction

  task automatic model_reset();
    m_prev = 0; m_unlock = 0; m_fill = 0; m_tpos = 0; m_ramp = 0; m_buzz = 0;
    m_fault = 1'b0; m_dir = 1'b0;
  endtask

  // One clock edge of the reference, using the inputs present at that edge.
  task automatic model_step();
    int s, pos, spd;
    bit entry, lock, tact, tdir, fto, vreq, dry, mreq, preq, inter, en, valve, motor, bz;
    s = int'(cs);
    if (s >= 10 && s <= 14) s = 0;
    entry  = (s != m_prev);
    m_prev = s;
    lock   = is_lock(s) || (m_unlock > 0);
    m_unlock = is_lock(s) ? UNLOCK : ((m_unlock > 0) ? m_unlock - 1 : 0);
    tact = 1'b0; tdir = 1'b0;
    if (s == 4 || s == 5) begin
      if (entry) m_tpos = 0;
      pos  = m_tpos % PERIOD;
      tact = (pos < ON) || (pos >= ON + PAUSE && pos < 2 * ON + PAUSE);
      tdir = (pos >= ON + PAUSE);
      m_tpos++;
    end
    if (s == 9 && entry) m_fill = 0;
    fto   = (s == 9) && (m_fill >= FILL_TO);
    vreq  = (s == 9) && !level_full && !fto;
    dry   = (s == 7) && level_empty;
    mreq  = tact || dry;
    preq  = (s == 6) || (s == 7);
    inter = !door_closed && lock && (vreq || mreq || preq);
    if (s == 0) m_fault = 1'b0;
    else if (inter || fto) m_fault = 1'b1;
    en    = door_closed && lock && !m_fault;
    valve = vreq && en;
    motor = mreq && en;
    if (valve) m_fill++;
    spd = 0;
    if (motor) spd = dry ? ((m_ramp < RAMP) ? 2 : 3) : ((s == 5) ? 2 : 1);
    m_ramp = dry ? m_ramp + 1 : 0;
    if (motor) m_dir = dry ? 1'b0 : tdir;
    if (s == 8 && entry) m_buzz = BUZZ;
    bz = (m_buzz > 0);
    if (m_buzz > 0) m_buzz--;
    exp_v = {lock, valve, preq, motor, m_dir, spd[1:0], bz, m_fault};
  endtask

  task automatic check(input string tag);
    got_v = {door_lock, inlet_valve, drain_pump, motor_en, motor_dir, motor_speed, buzzer, fault};
    n_tests++;
    assert (got_v === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s t=%0t cs=%0d got=%b exp=%b (lock,valve,pump,en,dir,spd[2],buzz,fault)",
             tag, $time, cs, got_v, exp_v);
    end
  endtask

  task automatic cyc(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_step();
      check(tag);
    end
  endtask

  initial begin
    model_reset();
    // Reset with Wash already presented: everything stays off.
    rst_n = 1'b0; cs = 4'd4; door_closed = 1'b1;
    #2;
    exp_v = '0; check("reset_async");
    @(posedge clk); #1;
    exp_v = '0; check("reset_held");
    rst_n = 1'b1;
    cyc(30, "wash_tumble");

    cs = 4'd9; level_full = 1'b0;
    cyc(55, "fill_timeout");
    cs = 4'd0;
    cyc(2, "fault_clear");

    cs = 4'd7; level_empty = 1'b0;
    cyc(3, "dry_wait");
    level_empty = 1'b1;
    cyc(10, "dry_ramp");
    level_empty = 1'b0;
    cyc(2, "dry_drop");
    level_empty = 1'b1;
    cyc(8, "dry_rearm");

    cs = 4'd5;
    cyc(5, "rinse_run");
    door_closed = 1'b0;
    cyc(2, "door_interlock");
    door_closed = 1'b1;
    cyc(5, "fault_sticky");
    cs = 4'd0;
    cyc(2, "interlock_clear");

    cs = 4'd7; level_empty = 1'b1;
    cyc(3, "dry_before_done");
    cs = 4'd8;
    cyc(15, "unlock_buzz");

    cs = 4'd5;
    cyc(10, "rinse");
    cs = 4'd4;
    cyc(10, "rinse_to_wash");
    cs = 4'd12;
    cyc(3, "undef_code");

    cs = 4'd6;
    cyc(3, "drain");
    rst_n = 1'b0;
    #1;
    model_reset();
    exp_v = '0; check("midcycle_reset");
    @(posedge clk); #1;
    check("reset_hold2");
    rst_n = 1'b1;
    cyc(2, "post_reset");

    for (int seg = 0; seg < 150; seg++) begin
      int hold;
      cs   = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 40);
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 39) == 0) door_closed = ~door_closed;
        else if (!door_closed && $urandom_range(0, 3) == 0) door_closed = 1'b1;
        if ($urandom_range(0, 15) == 0) level_full  = ~level_full;
        if ($urandom_range(0, 9) == 0)  level_empty = ~level_empty;
        cyc(1, "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
